switch_allocator_rr: RTL and testbench

// - Per-output round-robin switch allocator with starvation override for one router node.
// - Sits between the routing/agent stage (per-input one-hot output requests) and the one-hot packet switch.
// - Issues one-hot grants per output to the switch and pop enables per input to the input FIFOs.
// - Grants are combinational; arbitration pointers and per-input wait counters are registered.

---
 rtl/switch_allocator_rr_if.sv | 22 ++
 rtl/switch_allocator_rr.sv | 120 ++++++++++++
 tb/tb_switch_allocator_rr.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/switch_allocator_rr_if.sv
// Request/grant bundle between the route stage, the switch allocator and the packet switch.
// The allocator takes the slave side; the route stage / bench drive the master side.
interface switch_allocator_rr_if #(
  parameter int N = 5,
  parameter int M = 5
);
  logic [0:M-1]        i_en;
  logic [0:N-1][0:M-1] i_output_req;
  logic [0:M-1][0:N-1] o_output_grant;
  logic [0:N-1]        o_input_grant;
  logic [0:N-1]        o_starved;

  modport master (
    output i_en, i_output_req,
    input  o_output_grant, o_input_grant, o_starved
  );

  modport slave (
    input  i_en, i_output_req,
    output o_output_grant, o_input_grant, o_starved
  );
endinterface

// File: rtl/switch_allocator_rr.sv
// Per-output round-robin switch allocator with a starvation override.
// Grants are combinational; round-robin pointers and per-input wait counters are registered.
module switch_allocator_rr #(
  parameter int N            = 5,
  parameter int M            = 5,
  parameter int STARVE_LIMIT = 15,
  parameter int CW           = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  switch_allocator_rr_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [0:M-1][PW-1:0] ptr_q, ptr_d;
  logic [0:N-1][CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [0:N-1][0:M-1]  clean_req;
  logic [0:N-1]         requesting;
  logic [0:N-1]         starved;
  logic [0:M-1][0:N-1]  grant;
  logic [0:N-1]         input_grant;

  // A malformed row keeps only its lowest-index output so each input competes once.
  always_comb begin
    clean_req  = '0;
    requesting = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (bus.i_output_req[i][j] && !requesting[i]) begin
          clean_req[i][j] = 1'b1;
          requesting[i]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < N; i++) begin
      starved[i] = (wait_cnt_q[i] == LIMIT);
    end
  end

  // Starved eligible inputs win by lowest index; otherwise scan from the pointer.
  always_comb begin : arb_blk
    logic found;
    int   idx;
    int   cand;
    grant = '0;
    ptr_d = ptr_q;
    for (int j = 0; j < M; j++) begin
      found = 1'b0;
      idx   = 0;
      cand  = 0;
      if (ce && !reset && bus.i_en[j]) begin
        for (int i = 0; i < N; i++) begin
          if (!found && clean_req[i][j] && starved[i]) begin
            found = 1'b1;
            idx   = i;
          end
        end
        for (int k = 0; k < N; k++) begin
          cand = int'(ptr_q[j]) + k;
          if (cand >= N) begin
            cand = cand - N;
          end
          if (!found && clean_req[cand][j]) begin
            found = 1'b1;
            idx   = cand;
          end
        end
      end
      if (found) begin
        grant[j][idx] = 1'b1;
        ptr_d[j]      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_comb begin
    input_grant = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        input_grant[i] = input_grant[i] | grant[j][i];
      end
    end
  end

  // Blocked requests (including i_en backpressure) still age toward starvation.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (ce) begin
      for (int i = 0; i < N; i++) begin
        if (input_grant[i] || !requesting[i]) begin
          wait_cnt_d[i] = '0;
        end else if (wait_cnt_q[i] >= LIMIT) begin
          wait_cnt_d[i] = LIMIT;
        end else begin
          wait_cnt_d[i] = wait_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.o_output_grant = grant;
  assign bus.o_input_grant  = input_grant;
  assign bus.o_starved      = starved;
endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed bench for switch_allocator_rr with a queue-based allocation model checked every cycle.
// The DUT runs with STARVE_LIMIT=3 so saturation and the starvation override are reachable quickly.
module tb_switch_allocator_rr;
  localparam int N   = 5;
  localparam int M   = 5;
  localparam int LIM = 3;
  localparam int CW  = 4;

  logic clk;
  logic reset;
  logic ce;
  int   checks;
  int   errors;

  switch_allocator_rr_if #(.N(N), .M(M)) bus ();

  switch_allocator_rr #(
    .N(N), .M(M), .STARVE_LIMIT(LIM), .CW(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: pointer per output, wait count per input, plus next-state staging.
  int  m_ptr [M];
  int  m_wait[N];
  int  n_ptr [M];
  int  n_wait[N];
  bit  model_valid;
  logic [0:M-1][0:N-1] exp_og;
  logic [0:N-1]        exp_ig;
  logic [0:N-1]        exp_st;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int first_bit(input logic [0:M-1] row);
    for (int j = 0; j < M; j++) begin
      if (row[j]) return j;
    end
    return -1;
  endfunction

  // Winner for output j: lowest starved candidate, else the candidate nearest after the pointer.
  function automatic int pick(input int j);
    int cand[$];
    int best;
    if (!bus.i_en[j]) return -1;
    for (int i = 0; i < N; i++) begin
      if (first_bit(bus.i_output_req[i]) == j) cand.push_back(i);
    end
    if (cand.size() == 0) return -1;
    foreach (cand[k]) begin
      if (m_wait[cand[k]] == LIM) return cand[k];
    end
    best = cand[0];
    foreach (cand[k]) begin
      if ((cand[k] - m_ptr[j] + N) % N < (best - m_ptr[j] + N) % N) best = cand[k];
    end
    return best;
  endfunction

  task automatic model_step();
    int w;
    exp_og = '0;
    exp_ig = '0;
    for (int i = 0; i < N; i++) exp_st[i] = (m_wait[i] == LIM);
    n_ptr  = m_ptr;
    n_wait = m_wait;
    if (!reset && ce) begin
      for (int j = 0; j < M; j++) begin
        w = pick(j);
        if (w >= 0) begin
          exp_og[j][w] = 1'b1;
          exp_ig[w]    = 1'b1;
          n_ptr[j]     = (w + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (exp_ig[i]) n_wait[i] = 0;
        else if (first_bit(bus.i_output_req[i]) >= 0) n_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
        else n_wait[i] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      foreach (m_ptr[j]) m_ptr[j] = 0;
      foreach (m_wait[i]) m_wait[i] = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_ptr  = n_ptr;
      m_wait = n_wait;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      model_step();
      checkOutput("model_output_grant", 32'(bus.o_output_grant), 32'(exp_og));
      checkOutput("model_input_grant", 32'(bus.o_input_grant), 32'(exp_ig));
      checkOutput("model_starved", 32'(bus.o_starved), 32'(exp_st));
    end
  end

  function automatic logic [0:N-1][0:M-1] reqs(input logic [0:M-1] r0, r1, r2, r3, r4);
    return {r0, r1, r2, r3, r4};
  endfunction

  task automatic applyStimulus(input logic rst, input logic c, input logic [0:M-1] en,
                               input logic [0:N-1][0:M-1] req);
    @(posedge clk);
    #1;
    reset            = rst;
    ce               = c;
    bus.i_en         = en;
    bus.i_output_req = req;
    @(negedge clk);
  endtask

  logic [0:N-1][0:M-1] all4;
  logic [0:N-1][0:M-1] rr_req;
  logic [0:N-1][0:M-1] bp_req;
  logic [0:N-1][0:M-1] rnd_req;
  logic [0:N-1] rr_exp [6];
  logic [0:N-1] bp_starved [4];

  initial begin
    checks      = 0;
    errors      = 0;
    model_valid = 1'b0;
    all4   = reqs(5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001);
    rr_req = reqs(5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00000);
    bp_req = reqs(5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000);
    rr_exp     = '{5'b10000, 5'b01000, 5'b00010, 5'b10000, 5'b01000, 5'b00010};
    bp_starved = '{5'b00000, 5'b00000, 5'b00000, 5'b01010};

    reset            = 1'b1;
    ce               = 1'b1;
    bus.i_en         = '1;
    bus.i_output_req = all4;
    @(negedge clk);
    checkOutput("reset_out_grant", 32'(bus.o_output_grant), 32'd0);
    checkOutput("reset_in_grant", 32'(bus.o_input_grant), 32'd0);
    checkOutput("reset_starved", 32'(bus.o_starved), 32'd0);

    applyStimulus(1'b0, 1'b1, '1, all4);
    checkOutput("first_grant_out4", 32'(bus.o_output_grant[4]), 32'(5'b10000));
    checkOutput("first_in_grant", 32'(bus.o_input_grant), 32'(5'b10000));
    applyStimulus(1'b0, 1'b1, '1, all4);
    checkOutput("ptr4_advanced", 32'(bus.o_output_grant[4]), 32'(5'b01000));

    applyStimulus(1'b1, 1'b1, '1, all4);
    checkOutput("midrun_reset_grant", 32'(bus.o_input_grant), 32'd0);
    applyStimulus(1'b0, 1'b1, '1, reqs(5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000));
    checkOutput("single_out1", 32'(bus.o_output_grant[1]), 32'(5'b00100));
    checkOutput("single_in", 32'(bus.o_input_grant), 32'(5'b00100));
    applyStimulus(1'b0, 1'b1, '1, reqs(5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b01000));
    checkOutput("ptr1_is_3", 32'(bus.o_output_grant[1]), 32'(5'b00001));

    applyStimulus(1'b1, 1'b1, '1, '0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, '1, rr_req);
      checkOutput($sformatf("rr_grant_%0d", k), 32'(bus.o_output_grant[4]), 32'(rr_exp[k]));
      checkOutput($sformatf("rr_starved_%0d", k), 32'(bus.o_starved), 32'd0);
    end

    applyStimulus(1'b1, 1'b1, '1, '0);
    applyStimulus(1'b0, 1'b1, '1, reqs(5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000));
    checkOutput("bp_setup_ptr2", 32'(bus.o_output_grant[2]), 32'(5'b01000));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 5'b11011, bp_req);
      checkOutput($sformatf("bp_no_grant_%0d", k), 32'(bus.o_input_grant), 32'd0);
      checkOutput($sformatf("bp_starved_%0d", k), 32'(bus.o_starved), 32'(bp_starved[k]));
    end
    applyStimulus(1'b0, 1'b1, '1, bp_req);
    checkOutput("starve_override", 32'(bus.o_output_grant[2]), 32'(5'b01000));
    checkOutput("starve_flags", 32'(bus.o_starved), 32'(5'b01010));
    applyStimulus(1'b0, 1'b1, '1, bp_req);
    checkOutput("starved_next", 32'(bus.o_output_grant[2]), 32'(5'b00010));
    checkOutput("starved_next_flags", 32'(bus.o_starved), 32'(5'b00010));

    applyStimulus(1'b1, 1'b1, '1, '0);
    applyStimulus(1'b0, 1'b1, '1, reqs(5'b01010, 5'b00000, 5'b00010, 5'b00000, 5'b00000));
    checkOutput("malformed_out1", 32'(bus.o_output_grant[1]), 32'(5'b10000));
    checkOutput("malformed_out3", 32'(bus.o_output_grant[3]), 32'(5'b00100));
    checkOutput("malformed_in", 32'(bus.o_input_grant), 32'(5'b10100));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, '1, reqs(5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      checkOutput($sformatf("ce_off_out_%0d", k), 32'(bus.o_output_grant), 32'd0);
      checkOutput($sformatf("ce_off_in_%0d", k), 32'(bus.o_input_grant), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, '1, reqs(5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
    checkOutput("ce_ptr_held", 32'(bus.o_output_grant[1]), 32'(5'b01000));
    checkOutput("ce_wait_held", 32'(bus.o_starved), 32'd0);

    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < N; i++) begin
        rnd_req[i] = ($urandom_range(0, 2) != 0) ? 5'($urandom) : 5'b00000;
      end
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) != 0),
                    5'($urandom | $urandom), rnd_req);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
